ram_wr_enc: RTL
===============

// Module: ram_wr_enc
// PURPOSE
//  Write-side counterpart of the RAM read decoder. Decodes a write address
//  and stores write data into eight 16-bit RAM words (0x00-0x07), which feed
//  the read decoder. Writes to output port 0x40 (IO64) are queued in a small
//  FIFO and drained to the external device over a valid/ack handshake.
//  Sits between the CPU execute stage (store path) and the RAM/IO read side.
// PARAMETERS
//  IO_DEPTH     2      IO64 output FIFO depth in entries (power of 2, >=2)
//  IO_OUT_ADDR  8'h40  address of IO64 output port
//  IO_IN_ADDR   8'h41  address of IO65 input port (read-only; writes are errors)
// PORTS
//  CLK_WR      in   1   clock; all state updates on rising edge
//  RESET_N     in   1   asynchronous, active-low reset
//  RAM_WEN     in   1   write strobe, sampled each rising edge
//  RAM_AD_IN   in   8   write address
//  RAM_IN      in   16  write data
//  RAM_0..7    out  16  registered RAM words (8 ports)
//  IO64_OUT    out  16  FIFO head data
//  IO64_VALID  out  1   FIFO non-empty
//  IO64_ACK    in   1   consumer accepts head when IO64_VALID=1
//  IO_BUSY     out  1   FIFO full; producer must not write 0x40
//  WR_ERR      out  1   sticky error flag
//  ERR_CLR     in   1   clears WR_ERR
// BEHAVIOUR
//  Reset (async, RESET_N=0): RAM_0..7=0, FIFO empty, IO64_VALID=0,
//   IO64_OUT=0, IO_BUSY=0, WR_ERR=0. Reset mid-transfer discards queued data.
//  RAM write: RAM_WEN=1 & addr 0x00-0x07 -> RAM_n <= RAM_IN at that edge;
//   new value visible on RAM_n the following cycle (1-cycle latency).
//  IO write: RAM_WEN=1 & addr IO_OUT_ADDR -> push RAM_IN into FIFO.
//   Pushing into an empty FIFO: IO64_VALID rises next cycle (no bypass).
//  Drain: pop on edge where IO64_VALID & IO64_ACK; IO64_OUT shows the next
//   entry next cycle. IO64_ACK with IO64_VALID=0 is ignored.
//  Full: IO_BUSY = (count == IO_DEPTH). Push while full is accepted only if
//   a pop occurs on the same edge (count unchanged); otherwise data is
//   dropped and WR_ERR set.
//  Simultaneous push+pop on non-full, non-empty FIFO: count unchanged,
//   order preserved. Push+pop on empty: the pop is ignored, push is taken.
//  Error sources (RAM_WEN=1): address 0x08-0x3F, 0x42-0xFF, or IO_IN_ADDR
//   -> no state change except WR_ERR<=1; dropped IO push as above.
//  ERR_CLR=1 clears WR_ERR; if an error event occurs on the same edge, set
//   wins (WR_ERR stays 1).
//  Pointers wrap modulo IO_DEPTH; count width clog2(IO_DEPTH)+1.
//  RAM_WEN=0: address and data ignored, no error raised.
// STRUCTURE
//  Shared package/header: address constants (RAM_BASE 8'h00, RAM_WORDS 8,
//   IO_OUT_ADDR, IO_IN_ADDR), data width 16, address width 8 -- also used
//   by the read decoder so both sides agree on the map.
//  Sub-module io_out_fifo: IO_DEPTH x 16 FIFO with push/pop, full/empty,
//   count, async active-low reset. Top level holds decode, RAM registers and
//   the error flag.
// TESTING
//  1 Reset: hold RESET_N=0 mid-drain -> all outputs 0 immediately, no clock.
//  2 Write 0x1234 to addr 3 -> RAM_3=0x1234 next cycle; RAM_0..2,4..7
//    unchanged; WR_ERR=0.
//  3 Write 0xAAAA,0xBBBB to 0x40 with ACK=0 -> IO_BUSY=1, IO64_OUT=0xAAAA;
//    third write 0xCCCC -> dropped, WR_ERR=1; ACK twice -> 0xAAAA,0xBBBB out.
//  4 FIFO full, write 0xDDDD to 0x40 with ACK=1 same edge -> accepted,
//    IO_BUSY stays 1, next head 0xBBBB then 0xDDDD; WR_ERR=0.
//  5 Write to 0x41 and 0x08 -> RAM/FIFO unchanged, WR_ERR=1; ERR_CLR with
//    a simultaneous write to 0x90 -> WR_ERR stays 1; ERR_CLR alone -> 0.
//  6 Random RAM_WEN/addr/ACK vs. reference model for 10k cycles -> RAM words
//    and IO64 output order match model.

Source files
------------

// File: rtl/ram_wr_enc_pkg.sv
// Shared address map and data widths for the RAM write encoder and the
// RAM/IO read decoder, so both sides agree on where RAM and IO ports live.
package ram_wr_enc_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 8;
  localparam int RAM_WORDS = 8;
  localparam int RAM_IDX_W = $clog2(RAM_WORDS);

  localparam logic [ADDR_W-1:0] RAM_BASE        = 8'h00;
  localparam logic [ADDR_W-1:0] IO_OUT_ADDR_DEF = 8'h40;
  localparam logic [ADDR_W-1:0] IO_IN_ADDR_DEF  = 8'h41;

  // Classification of a write address.
  typedef enum logic [1:0] {
    ADDR_RAM     = 2'd0,
    ADDR_IO_OUT  = 2'd1,
    ADDR_IO_IN   = 2'd2,
    ADDR_ILLEGAL = 2'd3
  } addr_cls_e;

  typedef struct packed {
    addr_cls_e              cls;
    logic [RAM_IDX_W-1:0]   idx;  // RAM word index, meaningful for ADDR_RAM only
  } addr_dec_t;

  // Map an address to its class; the RAM window is RAM_BASE..RAM_BASE+RAM_WORDS-1.
  function automatic addr_dec_t decode_addr(input logic [ADDR_W-1:0] addr,
                                            input logic [ADDR_W-1:0] io_out,
                                            input logic [ADDR_W-1:0] io_in);
    logic [ADDR_W-1:0] off;
    addr_dec_t         d;
    off   = addr - RAM_BASE;
    d.idx = off[RAM_IDX_W-1:0];
    if (off < ADDR_W'(RAM_WORDS))  d.cls = ADDR_RAM;
    else if (addr == io_out)       d.cls = ADDR_IO_OUT;
    else if (addr == io_in)        d.cls = ADDR_IO_IN;
    else                           d.cls = ADDR_ILLEGAL;
    return d;
  endfunction

endpackage

// File: rtl/ram_wr_enc_if.sv
// Bus bundle between the store path / IO consumer and ram_wr_enc.
// IO64 handshake: o_io64_valid means o_io64_out holds the FIFO head; the
// head is consumed on a rising edge where o_io64_valid and i_io64_ack are
// both 1; i_io64_ack while o_io64_valid is 0 has no effect. The producer
// must not write the IO output address while o_io_busy is 1 unless it
// knows the head is being acked on that same edge.
interface ram_wr_enc_if;
  import ram_wr_enc_pkg::*;

  logic                                 i_ram_wen;
  logic [ADDR_W-1:0]                    i_ram_ad_in;
  logic [DATA_W-1:0]                    i_ram_in;
  logic [RAM_WORDS-1:0][DATA_W-1:0]     o_ram;
  logic [DATA_W-1:0]                    o_io64_out;
  logic                                 o_io64_valid;
  logic                                 i_io64_ack;
  logic                                 o_io_busy;
  logic                                 o_wr_err;
  logic                                 i_err_clr;

  modport master (
    output i_ram_wen, i_ram_ad_in, i_ram_in, i_io64_ack, i_err_clr,
    input  o_ram, o_io64_out, o_io64_valid, o_io_busy, o_wr_err
  );

  modport slave (
    input  i_ram_wen, i_ram_ad_in, i_ram_in, i_io64_ack, i_err_clr,
    output o_ram, o_io64_out, o_io64_valid, o_io_busy, o_wr_err
  );
endinterface

// File: rtl/ram_wr_enc_io_out_fifo.sv
// Small FIFO queueing IO64 output words. A push into a full FIFO is taken
// only when a pop happens on the same edge. Head data reads as zero when empty.
module ram_wr_enc_io_out_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [W-1:0]     i_wdata,
  output logic [W-1:0]     o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  // Storage: write the pushed word at the write pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ram_wr_enc.sv
// Write-side address decoder: stores into eight RAM words, queues IO64
// output writes, and keeps a sticky error flag for illegal or dropped writes.
module ram_wr_enc
  import ram_wr_enc_pkg::*;
#(
  parameter int                IO_DEPTH    = 2,
  parameter logic [ADDR_W-1:0] IO_OUT_ADDR = IO_OUT_ADDR_DEF,
  parameter logic [ADDR_W-1:0] IO_IN_ADDR  = IO_IN_ADDR_DEF
) (
  input logic          i_clk_wr,
  input logic          i_reset_n,
  ram_wr_enc_if.slave  bus
);

  localparam int CNT_W = $clog2(IO_DEPTH) + 1;

  addr_dec_t                        w_dec;
  logic                             w_ram_we;
  logic                             w_io_push;
  logic                             w_io_pop;
  logic                             w_bad_addr;
  logic                             w_push_drop;
  logic                             w_err_event;
  logic                             w_fifo_full;
  logic                             w_fifo_empty;
  logic [CNT_W-1:0]                 w_fifo_count;
  logic [DATA_W-1:0]                w_fifo_head;
  logic [RAM_WORDS-1:0][DATA_W-1:0] r_ram;
  logic                             r_wr_err;

  assign w_dec       = decode_addr(bus.i_ram_ad_in, IO_OUT_ADDR, IO_IN_ADDR);
  assign w_ram_we    = bus.i_ram_wen & (w_dec.cls == ADDR_RAM);
  assign w_io_push   = bus.i_ram_wen & (w_dec.cls == ADDR_IO_OUT);
  // The IO input port is read-only, so a write to it is as bad as an unmapped one.
  assign w_bad_addr  = bus.i_ram_wen & ((w_dec.cls == ADDR_IO_IN) ||
                                        (w_dec.cls == ADDR_ILLEGAL));
  assign w_io_pop    = bus.i_io64_ack & ~w_fifo_empty;
  // A push into a full FIFO survives only if the head leaves on the same edge.
  assign w_push_drop = w_io_push & w_fifo_full & ~w_io_pop;
  assign w_err_event = w_bad_addr | w_push_drop;

  ram_wr_enc_io_out_fifo #(
    .DEPTH (IO_DEPTH),
    .W     (DATA_W)
  ) u_io_out_fifo (
    .i_clk   (i_clk_wr),
    .i_rst_n (i_reset_n),
    .i_push  (w_io_push),
    .i_pop   (w_io_pop),
    .i_wdata (bus.i_ram_in),
    .o_rdata (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // RAM words: one-cycle write latency into the addressed word.
  always_ff @(posedge i_clk_wr or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ram <= '0;
    end else if (w_ram_we) begin
      r_ram[w_dec.idx] <= bus.i_ram_in;
    end
  end

  // Sticky error flag: a new error on the same edge beats a clear.
  always_ff @(posedge i_clk_wr or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_err <= 1'b0;
    end else if (w_err_event) begin
      r_wr_err <= 1'b1;
    end else if (bus.i_err_clr) begin
      r_wr_err <= 1'b0;
    end
  end

  assign bus.o_ram        = r_ram;
  assign bus.o_io64_out   = w_fifo_head;
  assign bus.o_io64_valid = ~w_fifo_empty;
  assign bus.o_io_busy    = (w_fifo_count == CNT_W'(IO_DEPTH));
  assign bus.o_wr_err     = r_wr_err;

endmodule
